// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 device-to-host receiver.
// Synchronises and de-glitches the raw PS/2 lines, deframes 11-bit frames
// and folds the E0 (extended) and F0 (break) prefixes into one strobe per key.
// Optional build macro PS2_ERR_EN adds an `err` pulse for dropped frames.
//
// Output handshake: kstb is a one-clock valid strobe with no ready; code,
// make and ext are valid in the kstb cycle and hold until the next kstb.
module ps2_keyboard_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 7000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       kstb,
    output logic       make,
    output logic [7:0] code,
    output logic       ext
`ifdef PS2_ERR_EN
    ,
    output logic       err
`endif
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic          ck_s1_q, ck_s2_q, d_s1_q, d_s2_q;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          flt_ck_q, flt_ck_d;
    logic          fall;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          ext_pf_q, ext_pf_d, brk_pf_q, brk_pf_d;
    logic          kstb_q, kstb_d, make_q, make_d, ext_q, ext_d;
    logic [7:0]    code_q, code_d;
`ifdef PS2_ERR_EN
    logic          err_q, err_d;
`endif

    // Two-flop synchronisers on the asynchronous PS/2 pins, every clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ck_s1_q <= 1'b1;
            ck_s2_q <= 1'b1;
            d_s1_q  <= 1'b1;
            d_s2_q  <= 1'b1;
        end else begin
            ck_s1_q <= ps2Ck;
            ck_s2_q <= ck_s1_q;
            d_s1_q  <= ps2D;
            d_s2_q  <= d_s1_q;
        end
    end

    // Clock filter: flip only after FILTER consecutive differing ce samples.
    always_comb begin
        flt_cnt_d = flt_cnt_q;
        flt_ck_d  = flt_ck_q;
        if (ce) begin
            if (ck_s2_q != flt_ck_q) begin
                if (flt_cnt_q == FW'(FILTER - 1)) begin
                    flt_ck_d  = ~flt_ck_q;
                    flt_cnt_d = '0;
                end else begin
                    flt_cnt_d = flt_cnt_q + FW'(1);
                end
            end else begin
                flt_cnt_d = '0;
            end
        end
        fall = flt_ck_q & ~flt_ck_d;
    end

    // Frame FSM, watchdog, prefix folding and output strobe generation.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        wdog_d    = wdog_q;
        ext_pf_d  = ext_pf_q;
        brk_pf_d  = brk_pf_q;
        kstb_d    = 1'b0;
        make_d    = make_q;
        code_d    = code_q;
        ext_d     = ext_q;
`ifdef PS2_ERR_EN
        err_d     = 1'b0;
`endif
        if (ce) begin
            if (fall || state_q == S_IDLE) begin
                wdog_d = '0;
            end else if (wdog_q != TW'(TIMEOUT)) begin
                wdog_d = wdog_q + TW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (fall && !d_s2_q) begin
                        state_d   = S_SHIFT;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_SHIFT: begin
                    if (fall) begin
                        shift_d   = {d_s2_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (fall) begin
                        par_d   = d_s2_q;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall) begin
                        state_d = S_IDLE;
                        if ((^shift_q ^ par_q) && d_s2_q) begin
                            if (shift_q == 8'hE0) begin
                                ext_pf_d = 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brk_pf_d = 1'b1;
                            end else begin
                                kstb_d   = 1'b1;
                                code_d   = shift_q;
                                make_d   = ~brk_pf_q;
                                ext_d    = ext_pf_q;
                                ext_pf_d = 1'b0;
                                brk_pf_d = 1'b0;
                            end
                        end else begin
                            ext_pf_d = 1'b0;
                            brk_pf_d = 1'b0;
`ifdef PS2_ERR_EN
                            err_d    = 1'b1;
`endif
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // Watchdog expiry; a coincident falling edge takes priority.
            if (state_q != S_IDLE && !fall && wdog_q == TW'(TIMEOUT - 1)) begin
                state_d  = S_IDLE;
                ext_pf_d = 1'b0;
                brk_pf_d = 1'b0;
`ifdef PS2_ERR_EN
                err_d    = 1'b1;
`endif
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flt_cnt_q <= '0;
            flt_ck_q  <= 1'b1;
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            wdog_q    <= '0;
            ext_pf_q  <= 1'b0;
            brk_pf_q  <= 1'b0;
            kstb_q    <= 1'b0;
            make_q    <= 1'b0;
            code_q    <= 8'h00;
            ext_q     <= 1'b0;
`ifdef PS2_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            flt_cnt_q <= flt_cnt_d;
            flt_ck_q  <= flt_ck_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            wdog_q    <= wdog_d;
            ext_pf_q  <= ext_pf_d;
            brk_pf_q  <= brk_pf_d;
            kstb_q    <= kstb_d;
            make_q    <= make_d;
            code_q    <= code_d;
            ext_q     <= ext_d;
`ifdef PS2_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign kstb = kstb_q;
    assign make = make_q;
    assign code = code_q;
    assign ext  = ext_q;
`ifdef PS2_ERR_EN
    assign err  = err_q;
`endif

endmodule
